// File: rtl/uart_rx_ctrl.sv
// UART receive controller: tick generator, 2-flop input synchronizer,
// start/data/stop sequencer, FWFT receive FIFO and sticky error flags.
// Ports: clk, reset (sync, active-high), rx_en, rxd, clr_err, os_tick,
//        rx_data/rx_valid/rx_ready (FIFO head handshake), busy,
//        framing_err, overrun, fifo_count.
module uart_rx_ctrl #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_en,
    input  logic                          rxd,
    input  logic                          clr_err,
    output logic                          os_tick,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          busy,
    output logic                          framing_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_IDLE
    } state_t;

    logic [DW-1:0]        div_cnt;
    logic                 sync1;
    logic                 rxd_s;
    state_t               state;
    logic [TW-1:0]        tcnt;
    logic [TW-1:0]        tcnt_nx;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_pt;
    logic                 push;
    logic                 ferr_set;
    logic                 ovr_set;
    logic                 pop;
    logic                 full;
    logic                 do_push;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    // Tick generator runs regardless of rx_en
    always_ff @(posedge clk) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == DW'(CLK_DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign os_tick = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    // tcnt_nx is the count this tick brings us to
    assign tcnt_nx  = tcnt + 1'b1;
    assign stop_pt  = rx_en && (state == STOP) && os_tick &&
                      (tcnt_nx == TW'(OVERSAMPLE));
    assign push     = stop_pt && rxd_s;
    assign ferr_set = stop_pt && !rxd_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tcnt   <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else if (!rx_en) begin
            state <= IDLE;
            tcnt  <= '0;
        end else if (os_tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        tcnt  <= TW'(1);
                    end
                end
                START: begin
                    if (tcnt_nx == TW'(OVERSAMPLE / 2)) begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            state  <= DATA;
                            tcnt   <= '0;
                            bitcnt <= '0;
                        end
                    end else begin
                        tcnt <= tcnt_nx;
                    end
                end
                DATA: begin
                    if (tcnt_nx == TW'(OVERSAMPLE)) begin
                        // LSB arrives first, so shift in from the top
                        shift <= {rxd_s, shift[DATA_BITS-1:1]};
                        tcnt  <= '0;
                        if (bitcnt == BW'(DATA_BITS - 1))
                            state <= STOP;
                        else
                            bitcnt <= bitcnt + 1'b1;
                    end else begin
                        tcnt <= tcnt_nx;
                    end
                end
                STOP: begin
                    if (tcnt_nx == TW'(OVERSAMPLE)) begin
                        state <= rxd_s ? IDLE : WAIT_IDLE;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt_nx;
                    end
                end
                WAIT_IDLE: begin
                    if (rxd_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // FIFO: a push into a full FIFO only lands if the head leaves this cycle
    assign rx_valid = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = rx_valid && rx_ready;
    assign do_push  = push && (!full || pop);
    assign ovr_set  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(pop);
        end
    end

    assign rx_data    = rx_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

    // Set beats clear when both land in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= ferr_set || (framing_err && !clr_err);
            overrun     <= ovr_set || (overrun && !clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with CLK_DIV=4, OVERSAMPLE=8.
// One bit period is 32 clocks; frames start aligned to a tick cycle.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_en;
    logic       rxd;
    logic       clr_err;
    logic       os_tick;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       framing_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int vcyc   = 0;
    logic [7:0] got [$];

    uart_rx_ctrl #(
        .CLK_DIV(4),
        .OVERSAMPLE(8),
        .DATA_BITS(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_en(rx_en),
        .rxd(rxd),
        .clr_err(clr_err),
        .os_tick(os_tick),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .busy(busy),
        .framing_err(framing_err),
        .overrun(overrun),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Record every accepted byte and every cycle rx_valid is high
    always @(negedge clk) begin
        if (rx_valid)
            vcyc++;
        if (rx_valid && rx_ready)
            got.push_back(rx_data);
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] qat(input int i);
        if (i < got.size())
            return got[i];
        return 8'hxx;
    endfunction

    task automatic align();
        int k = 0;
        while (!os_tick && k < 8) begin
            cyc(1);
            k++;
        end
        if (!os_tick)
            chk("tick_align", 32'(os_tick), 32'd1);
    endtask

    // Stop sample lands 17 edges into the stop bit; pulse puts rx_ready
    // high for exactly that cycle.
    task automatic send(input logic [7:0] d, input logic stopb,
                        input bit pulse);
        align();
        rxd = 1'b0;
        cyc(32);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cyc(32);
        end
        rxd = stopb;
        if (pulse) begin
            cyc(16);
            rx_ready = 1'b1;
            cyc(1);
            rx_ready = 1'b0;
            cyc(15);
        end else begin
            cyc(32);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_en    = 1'b1;
        rxd      = 1'b1;
        clr_err  = 1'b0;
        rx_ready = 1'b0;
        cyc(3);
        chk("rst_tick", 32'(os_tick), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(framing_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_cnt", 32'(fifo_count), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Clean frame with consumer always ready
        rx_ready = 1'b1;
        got.delete();
        vcyc = 0;
        send(8'hA5, 1'b1, 1'b0);
        cyc(4);
        chk("a5_n", 32'(got.size()), 32'd1);
        chk("a5_data", 32'(qat(0)), 32'hA5);
        chk("a5_vcyc", 32'(vcyc), 32'd1);
        chk("a5_cnt", 32'(fifo_count), 32'd0);
        chk("a5_ferr", 32'(framing_err), 32'd0);
        chk("a5_busy", 32'(busy), 32'd0);

        // Glitch: start bit too short
        align();
        rxd = 1'b0;
        cyc(8);
        chk("glitch_busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        cyc(40);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_n", 32'(got.size()), 32'd1);
        chk("glitch_ferr", 32'(framing_err), 32'd0);

        // rx_en dropped mid-frame
        align();
        rxd = 1'b0;
        cyc(50);
        chk("en_busy", 32'(busy), 32'd1);
        rx_en = 1'b0;
        cyc(1);
        chk("en_idle", 32'(busy), 32'd0);
        rxd = 1'b1;
        cyc(20);
        rx_en = 1'b1;
        chk("en_cnt", 32'(fifo_count), 32'd0);
        chk("en_ferr", 32'(framing_err), 32'd0);

        // Framing error with line stuck low
        send(8'h3C, 1'b0, 1'b0);
        cyc(96);
        chk("fe_flag", 32'(framing_err), 32'd1);
        chk("fe_busy", 32'(busy), 32'd1);
        chk("fe_cnt", 32'(fifo_count), 32'd0);
        rxd = 1'b1;
        cyc(12);
        chk("fe_idle", 32'(busy), 32'd0);
        chk("fe_sticky", 32'(framing_err), 32'd1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("fe_clr", 32'(framing_err), 32'd0);

        // Overrun: five bytes into a four-deep FIFO
        rx_ready = 1'b0;
        for (int b = 1; b <= 5; b++)
            send(8'(b), 1'b1, 1'b0);
        cyc(4);
        chk("ov_cnt", 32'(fifo_count), 32'd4);
        chk("ov_head", 32'(rx_data), 32'h01);
        chk("ov_flag", 32'(overrun), 32'd1);
        got.delete();
        rx_ready = 1'b1;
        cyc(6);
        rx_ready = 1'b0;
        chk("ov_n", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("ov_order", 32'(qat(i)), 32'(i + 1));
        chk("ov_empty", 32'(fifo_count), 32'd0);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("ov_clr", 32'(overrun), 32'd0);

        // Full FIFO, pop in the same cycle as the push
        for (int b = 0; b < 4; b++)
            send(8'(8'h10 + b), 1'b1, 1'b0);
        got.delete();
        send(8'h14, 1'b1, 1'b1);
        cyc(2);
        chk("fp_cnt", 32'(fifo_count), 32'd4);
        chk("fp_ovr", 32'(overrun), 32'd0);
        chk("fp_head", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        cyc(6);
        rx_ready = 1'b0;
        chk("fp_n", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("fp_order", 32'(qat(i)), 32'(8'h10 + i));

        // Reset mid-DATA with two bytes buffered
        send(8'h55, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        chk("mr_cnt0", 32'(fifo_count), 32'd2);
        align();
        rxd = 1'b0;
        cyc(80);
        chk("mr_busy0", 32'(busy), 32'd1);
        reset = 1'b1;
        cyc(1);
        chk("mr_valid", 32'(rx_valid), 32'd0);
        chk("mr_cnt", 32'(fifo_count), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_ferr", 32'(framing_err), 32'd0);
        chk("mr_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        rxd = 1'b1;
        cyc(20);
        got.delete();
        rx_ready = 1'b1;
        send(8'h7E, 1'b1, 1'b0);
        cyc(4);
        chk("mr_n", 32'(got.size()), 32'd1);
        chk("mr_7e", 32'(qat(0)), 32'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART. It owns the oversample tick generator and the input synchronizer, and sequences start/data/stop sampling of the serial line. Completed bytes are buffered in a small FIFO and presented to the system bus through a valid/ready handshake, with framing and overrun status. It replaces free-running receive sequencing with a single clock-synchronous controller.

Parameters:
CLK_DIV, 27, system clocks per oversample tick (≥2)
OVERSAMPLE, 8, ticks per bit period (even, ≥4)
DATA_BITS, 8, data bits per frame, LSB first
FIFO_DEPTH, 4, receive buffer entries (power of 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  reset, synchronous, active-high
rx_en  input  1  receive enable; low forces IDLE
rxd  input  1  asynchronous serial line, idle high
clr_err  input  1  one-cycle pulse, clears sticky error flags
os_tick  output  1  one-cycle oversample tick pulse
rx_data  output  DATA_BITS  head-of-FIFO byte
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts head byte when rx_valid&&rx_ready
busy  output  1  FSM not in IDLE
framing_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte dropped, FIFO full
fifo_count  output  clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset values: os_tick=0, rx_data=0, rx_valid=0, busy=0, framing_err=0, overrun=0, fifo_count=0; synchronizer flops=1; tick counter=0; FSM=IDLE; FIFO pointers=0.
- Synchronizer: 2-flop; rxd_s = second stage. All decisions use rxd_s only.
- Tick gen: free-running counter 0..CLK_DIV-1; os_tick=1 on the cycle the counter equals CLK_DIV-1, then wraps to 0. Runs regardless of rx_en.
- Per-bit tick counter (tcnt) advances only on os_tick.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_en=1 and rxd_s=0 on an os_tick → START, tcnt=1.
- START: when tcnt reaches OVERSAMPLE/2, rxd_s=1 → IDLE (false start, no flag); rxd_s=0 → DATA, tcnt=0, bitcnt=0.
- DATA: each time tcnt reaches OVERSAMPLE, sample rxd_s into shift[bitcnt], bitcnt+1, tcnt=0. After DATA_BITS samples → STOP.
- STOP: at tcnt=OVERSAMPLE, rxd_s=1 → push byte, → IDLE; rxd_s=0 → set framing_err, discard byte, → WAIT_IDLE.
- WAIT_IDLE: remain until rxd_s=1 on an os_tick, then → IDLE. No bytes are pushed.
- Latency: pushed byte is visible on rx_data/rx_valid the clock after the stop-sample cycle.
- FIFO: first-word fall-through; rx_data = head entry. Pop on rx_valid&&rx_ready.
- Push when full with no pop: byte dropped, overrun set, contents unchanged.
- Push and pop in the same cycle when full: both occur; count unchanged; no overrun.
- Push and pop in the same cycle when empty: not possible, because the byte becomes visible one cycle later.
- Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: cleared by clr_err. If a set event and clr_err occur in the same cycle, set wins.
- rx_en deasserted mid-frame: on the next clk → IDLE, partial byte discarded, no flags. FIFO and flags are retained; popping continues.
- busy=1 in START/DATA/STOP/WAIT_IDLE.
- reset mid-frame or with a non-empty FIFO: all state returns to reset values on that clock.

Test Plan:
Use CLK_DIV=4, OVERSAMPLE=8, so one bit = 32 clocks.
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5, fifo_count back to 0, no flags.
- rxd low for 8 clocks then high → START aborts to IDLE, busy returns to 0, no push, no flags.
- Frame 0x3C with stop bit 0, then line held low 3 bit times → framing_err=1, fifo_count=0, FSM in WAIT_IDLE until line high. clr_err → framing_err=0.
- rx_ready=0, send 0x01..0x05 → fifo_count=4, rx_data=0x01, overrun=1. Then rx_ready=1 → pops 0x01..0x04 in order.
- FIFO full, rx_ready asserted on the same cycle the 5th byte is pushed → no overrun, count stays 4, 5th byte is last out.
- reset asserted mid-DATA with 2 bytes buffered → next cycle: rx_valid=0, fifo_count=0, busy=0, flags=0. A following frame 0x7E is received correctly.
